// File: rtl/mips_pkg.sv
// Shared MIPS core types: register address, data width, writeback payload
// and arbiter priority state.
package mips_pkg;

  localparam int unsigned DATA_32_W            = 32;
  localparam int unsigned REG_ADDR_W           = 5;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef logic [REG_ADDR_W-1:0] t_instr_register;

  // Writeback request payload carried from either producer to the bank
  typedef struct packed {
    t_instr_register       addr;
    logic [DATA_32_W-1:0]  data;
  } t_wb_req;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } t_wb_pri;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write tracker: one busy bit per architectural register, set on
// issue and cleared when the register-bank write for it completes.
// Ports: clk, rst (async active-low), issue_valid/issue_rd (set),
//        clr_valid/clr_addr (clear), chk_addr_1/2 -> hazard_1/2 (comb),
//        busy_vec (registered pending bits).
module wb_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned REG_FILE_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  t_instr_register           issue_rd,
  input  logic                      clr_valid,
  input  t_instr_register           clr_addr,
  input  t_instr_register           chk_addr_1,
  input  t_instr_register           chk_addr_2,
  output logic                      hazard_1,
  output logic                      hazard_2,
  output logic [REG_FILE_DEPTH-1:0] busy_vec
);

  logic [REG_FILE_DEPTH-1:0] busy_next;

  // Clear first, then set, so a same-edge issue keeps the bit high.
  // Register 0 is never set, so its bit stays at its reset value of 0.
  always_comb begin
    busy_next = busy_vec;
    for (int unsigned i = 1; i < REG_FILE_DEPTH; i++) begin
      if (clr_valid && (clr_addr == REG_ADDR_W'(i))) busy_next[i] = 1'b0;
      if (issue_valid && (issue_rd == REG_ADDR_W'(i))) busy_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_vec <= '0;
    else      busy_vec <= busy_next;
  end

  // Hazard lookup; addresses outside the tracked range and r0 never hazard
  always_comb begin
    hazard_1 = 1'b0;
    hazard_2 = 1'b0;
    for (int unsigned i = 1; i < REG_FILE_DEPTH; i++) begin
      if (chk_addr_1 == REG_ADDR_W'(i)) hazard_1 = busy_vec[i];
      if (chk_addr_2 == REG_ADDR_W'(i)) hazard_2 = busy_vec[i];
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single register-bank
// write port, with starvation protection for the load unit, and tracks
// pending writes for decode hazard detection.
// Ports: clk, rst (async active-low); alu_wb_* / mem_wb_* valid-ready
//        request ports; issue_valid/issue_rd; chk_addr_1/2 -> hazard_1/2;
//        reg_file_write/wr_addr/wr_data (registered, one cycle after
//        accept); busy_vec.
module regbank_wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned REG_FILE_DEPTH = 16,
  parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_wb_valid,
  output logic                      alu_wb_ready,
  input  t_instr_register           alu_wb_addr,
  input  logic [DATA_32_W-1:0]      alu_wb_data,
  input  logic                      mem_wb_valid,
  output logic                      mem_wb_ready,
  input  t_instr_register           mem_wb_addr,
  input  logic [DATA_32_W-1:0]      mem_wb_data,
  input  logic                      issue_valid,
  input  t_instr_register           issue_rd,
  input  t_instr_register           chk_addr_1,
  input  t_instr_register           chk_addr_2,
  output logic                      hazard_1,
  output logic                      hazard_2,
  output logic                      reg_file_write,
  output t_instr_register           reg_file_wr_addr,
  output logic [DATA_32_W-1:0]      reg_file_wr_data,
  output logic [REG_FILE_DEPTH-1:0] busy_vec
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  t_wb_pri          state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  t_wb_req          winner;
  logic             accept;

  // Priority state and starvation counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PRI_ALU;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grant selection and next-state; readies are held low during reset
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    alu_wb_ready = 1'b0;
    mem_wb_ready = 1'b0;
    if (rst) begin
      if (mem_wb_valid && ((state_q == PRI_MEM) || !alu_wb_valid)) mem_wb_ready = 1'b1;
      else if (alu_wb_valid)                                        alu_wb_ready = 1'b1;
    end
    if (mem_wb_ready) begin
      starve_d = '0;
      state_d  = PRI_ALU;
    end else if (mem_wb_valid) begin
      if (starve_q < CNT_W'(STARVE_LIMIT)) starve_d = starve_q + CNT_W'(1);
      if (starve_d >= CNT_W'(STARVE_LIMIT)) state_d = PRI_MEM;
    end
  end

  always_comb begin
    accept = alu_wb_ready || mem_wb_ready;
    winner = mem_wb_ready ? t_wb_req'{addr: mem_wb_addr, data: mem_wb_data}
                          : t_wb_req'{addr: alu_wb_addr, data: alu_wb_data};
  end

  // Write port register: one write cycle per accept, none for r0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_file_write   <= 1'b0;
      reg_file_wr_addr <= '0;
      reg_file_wr_data <= '0;
    end else begin
      reg_file_write   <= accept && (winner.addr != '0);
      reg_file_wr_addr <= accept ? winner.addr : '0;
      reg_file_wr_data <= accept ? winner.data : '0;
    end
  end

  wb_scoreboard #(
    .REG_FILE_DEPTH (REG_FILE_DEPTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_valid   (reg_file_write),
    .clr_addr    (reg_file_wr_addr),
    .chk_addr_1  (chk_addr_1),
    .chk_addr_2  (chk_addr_2),
    .hazard_1    (hazard_1),
    .hazard_2    (hazard_2),
    .busy_vec    (busy_vec)
  );

endmodule
